// File: rtl/skip_pattern_decoder.sv
// Rebuilds the per-frame skip mask of a skip-ring gated clock and tracks frame lock.
// Optional mismatch counter: define SKIP_PATTERN_DECODER_ERRCNT_EN.
module skip_pattern_decoder #(
  parameter int LEN  = 16,
  parameter int CNTW = 8
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            EN,
  input  logic            SLOT0,
  input  logic            SLOT_PRES,
  input  logic [LEN-1:0]  EXPECT,
  input  logic            READY,
  output logic [LEN-1:0]  MASK_OUT,
  output logic            VALID,
  output logic            MISMATCH,
  output logic            LOCKED,
  output logic            SYNC_ERR,
  output logic            OVERRUN,
  output logic [CNTW-1:0] ERRCNT
);

  localparam int IW = $clog2(LEN);
  localparam logic [IW-1:0] LAST = IW'(LEN - 1);
  localparam logic [IW-1:0] ZERO = {IW{1'b0}};
  localparam logic [IW-1:0] ONE  = IW'(1);

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    ACQ  = 2'd1,
    LOCK = 2'd2
  } state_t;

  state_t          state;
  logic [IW-1:0]   idx;
  logic [LEN-1:0]  cap;
  logic [LEN-1:0]  frame_mask;
  logic [LEN-1:0]  restart_cap;
  logic            complete;
  logic            frame_mismatch;

  // The last slot completes the frame on its own edge, so it bypasses the capture register
  assign frame_mask     = {~SLOT_PRES, cap[LEN-2:0]};
  assign restart_cap    = {{(LEN-1){1'b0}}, ~SLOT_PRES};
  assign complete       = EN && (state != HUNT) && (idx == LAST) && !SLOT0;
  assign frame_mismatch = (frame_mask != EXPECT);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= HUNT;
      idx      <= ZERO;
      cap      <= {LEN{1'b0}};
      MASK_OUT <= {LEN{1'b0}};
      VALID    <= 1'b0;
      MISMATCH <= 1'b0;
      LOCKED   <= 1'b0;
      SYNC_ERR <= 1'b0;
      OVERRUN  <= 1'b0;
    end else begin
      SYNC_ERR <= 1'b0;
      OVERRUN  <= 1'b0;

      // Holding register: a completing frame always wins over consumption
      if (complete) begin
        MASK_OUT <= frame_mask;
        MISMATCH <= frame_mismatch;
        VALID    <= 1'b1;
        OVERRUN  <= VALID && !READY;
      end else if (VALID && READY) begin
        VALID <= 1'b0;
      end

      if (EN) begin
        case (state)
          HUNT: begin
            if (SLOT0) begin
              cap   <= restart_cap;
              idx   <= ONE;
              state <= ACQ;
            end
          end
          ACQ, LOCK: begin
            if (idx == ZERO) begin
              if (SLOT0) begin
                cap <= restart_cap;
                idx <= ONE;
              end else begin
                SYNC_ERR <= 1'b1;
                LOCKED   <= 1'b0;
                state    <= HUNT;
              end
            end else if (SLOT0) begin
              // Early marker: drop the partial frame and realign on this slot
              SYNC_ERR <= 1'b1;
              LOCKED   <= 1'b0;
              cap      <= restart_cap;
              idx      <= ONE;
              state    <= ACQ;
            end else if (idx == LAST) begin
              idx    <= ZERO;
              state  <= LOCK;
              LOCKED <= 1'b1;
            end else begin
              cap[idx] <= ~SLOT_PRES;
              idx      <= idx + ONE;
            end
          end
          default: begin
            state <= HUNT;
            idx   <= ZERO;
          end
        endcase
      end
    end
  end

`ifdef SKIP_PATTERN_DECODER_ERRCNT_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      ERRCNT <= {CNTW{1'b0}};
    end else if (complete && frame_mismatch && (ERRCNT != {CNTW{1'b1}})) begin
      ERRCNT <= ERRCNT + CNTW'(1);
    end
  end
`else
  assign ERRCNT = {CNTW{1'b0}};
`endif

endmodule

// File: tb/tb_skip_pattern_decoder.sv
// Directed self-checking bench for skip_pattern_decoder (LEN=16, CNTW=8).
module tb_skip_pattern_decoder;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        EN = 1'b0;
  logic        SLOT0 = 1'b0;
  logic        SLOT_PRES = 1'b1;
  logic [15:0] EXPECT = 16'h0000;
  logic        READY = 1'b1;
  logic [15:0] MASK_OUT;
  logic        VALID;
  logic        MISMATCH;
  logic        LOCKED;
  logic        SYNC_ERR;
  logic        OVERRUN;
  logic [7:0]  ERRCNT;

  int n_checks = 0;
  int n_pass   = 0;

`ifdef SKIP_PATTERN_DECODER_ERRCNT_EN
  localparam logic [7:0] EXP_ERR3   = 8'd3;
  localparam logic [7:0] EXP_ERR300 = 8'd255;
`else
  localparam logic [7:0] EXP_ERR3   = 8'd0;
  localparam logic [7:0] EXP_ERR300 = 8'd0;
`endif

  skip_pattern_decoder #(.LEN(16), .CNTW(8)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .SLOT0(SLOT0), .SLOT_PRES(SLOT_PRES),
    .EXPECT(EXPECT), .READY(READY), .MASK_OUT(MASK_OUT), .VALID(VALID),
    .MISMATCH(MISMATCH), .LOCKED(LOCKED), .SYNC_ERR(SYNC_ERR),
    .OVERRUN(OVERRUN), .ERRCNT(ERRCNT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Present one slot and let it take effect; outputs are read 1 ns after the edge
  task automatic do_slot(input logic en, input logic s0, input logic pres, input logic rdy);
    EN = en; SLOT0 = s0; SLOT_PRES = pres; READY = rdy;
    @(posedge CLK); #1;
  endtask

  task automatic send_frame(input logic [15:0] mask, input logic [15:0] exp,
                            input logic rdy, input logic rdy_last);
    EXPECT = exp;
    for (int i = 0; i < 16; i++)
      do_slot(1'b1, i == 0, ~mask[i], (i == 15) ? rdy_last : rdy);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mask"}, 32'(MASK_OUT), 32'h0);
    check({tag, "_valid"}, 32'(VALID), 32'h0);
    check({tag, "_mism"}, 32'(MISMATCH), 32'h0);
    check({tag, "_locked"}, 32'(LOCKED), 32'h0);
    check({tag, "_syncerr"}, 32'(SYNC_ERR), 32'h0);
    check({tag, "_overrun"}, 32'(OVERRUN), 32'h0);
    check({tag, "_errcnt"}, 32'(ERRCNT), 32'h0);
  endtask

  initial begin
    logic [15:0] m;
    RST = 1'b1;
    do_slot(1'b0, 1'b0, 1'b1, 1'b1);
    do_slot(1'b0, 1'b0, 1'b1, 1'b1);
    check_all_zero("reset");
    RST = 1'b0;

    // 1: slots 3 and 7 skipped
    send_frame(16'h0088, 16'h0088, 1'b1, 1'b1);
    check("s1_valid", 32'(VALID), 32'h1);
    check("s1_mask", 32'(MASK_OUT), 32'h0088);
    check("s1_mism", 32'(MISMATCH), 32'h0);
    check("s1_locked", 32'(LOCKED), 32'h1);

    // 2: mismatching frames, then saturation
    for (int f = 0; f < 3; f++) begin
      send_frame(16'h0089, 16'h0088, 1'b1, 1'b1);
      check("s2_mism", 32'(MISMATCH), 32'h1);
      check("s2_mask", 32'(MASK_OUT), 32'h0089);
    end
    check("s2_errcnt3", 32'(ERRCNT), 32'(EXP_ERR3));
    for (int f = 0; f < 297; f++) send_frame(16'h0089, 16'h0088, 1'b1, 1'b1);
    check("s2_errcnt_sat", 32'(ERRCNT), 32'(EXP_ERR300));

    // 3: overrun with READY low, then completion coinciding with READY
    do_slot(1'b0, 1'b0, 1'b1, 1'b1);
    check("s3_drain", 32'(VALID), 32'h0);
    send_frame(16'h0001, 16'h0001, 1'b0, 1'b0);
    check("s3_ovr_first", 32'(OVERRUN), 32'h0);
    check("s3_mask1", 32'(MASK_OUT), 32'h0001);
    send_frame(16'h0002, 16'h0002, 1'b0, 1'b0);
    check("s3_ovr", 32'(OVERRUN), 32'h1);
    check("s3_mask2", 32'(MASK_OUT), 32'h0002);
    check("s3_valid2", 32'(VALID), 32'h1);
    send_frame(16'h0004, 16'h0004, 1'b0, 1'b1);
    check("s3_ovr_rdy", 32'(OVERRUN), 32'h0);
    check("s3_valid3", 32'(VALID), 32'h1);
    check("s3_mask3", 32'(MASK_OUT), 32'h0004);
    check("s2_errcnt_hold", 32'(ERRCNT), 32'(EXP_ERR300));

    // 4: early marker at slot 5, then missing marker
    EXPECT = 16'h0003;
    for (int i = 0; i < 5; i++) do_slot(1'b1, i == 0, 1'b1, 1'b1);
    m = 16'h0003;
    do_slot(1'b1, 1'b1, ~m[0], 1'b1);
    check("s4_early_err", 32'(SYNC_ERR), 32'h1);
    check("s4_early_unlock", 32'(LOCKED), 32'h0);
    for (int i = 1; i < 16; i++) begin
      do_slot(1'b1, 1'b0, ~m[i], 1'b1);
      if (i == 1) check("s4_pulse_end", 32'(SYNC_ERR), 32'h0);
      if (i == 14) check("s4_not_yet", 32'(VALID), 32'h0);
    end
    check("s4_valid", 32'(VALID), 32'h1);
    check("s4_mask", 32'(MASK_OUT), 32'h0003);
    check("s4_mism", 32'(MISMATCH), 32'h0);
    check("s4_relock", 32'(LOCKED), 32'h1);
    do_slot(1'b1, 1'b0, 1'b1, 1'b1);
    check("s4_miss_err", 32'(SYNC_ERR), 32'h1);
    check("s4_miss_unlock", 32'(LOCKED), 32'h0);
    for (int i = 0; i < 5; i++) do_slot(1'b1, 1'b0, 1'b0, 1'b1);
    check("s4_hunt_quiet", 32'(SYNC_ERR), 32'h0);
    send_frame(16'h0010, 16'h0010, 1'b1, 1'b1);
    check("s4_hunt_mask", 32'(MASK_OUT), 32'h0010);
    check("s4_hunt_lock", 32'(LOCKED), 32'h1);

    // 5: 10-cycle EN gap after slot 8; SLOT0 toggled during the gap must be ignored
    m = 16'h8001;
    EXPECT = m;
    for (int i = 0; i < 9; i++) do_slot(1'b1, i == 0, ~m[i], 1'b1);
    for (int i = 0; i < 10; i++) do_slot(1'b0, 1'b1, 1'b0, 1'b1);
    check("s5_gap_lock", 32'(LOCKED), 32'h1);
    check("s5_gap_sync", 32'(SYNC_ERR), 32'h0);
    for (int i = 9; i < 15; i++) do_slot(1'b1, 1'b0, ~m[i], 1'b1);
    check("s5_cycle25", 32'(VALID), 32'h0);
    do_slot(1'b1, 1'b0, ~m[15], 1'b1);
    check("s5_cycle26", 32'(VALID), 32'h1);
    check("s5_mask", 32'(MASK_OUT), 32'h8001);

    // 6: reset in mid-frame with an unconsumed frame held
    for (int i = 0; i < 8; i++) do_slot(1'b1, i == 0, 1'b1, 1'b0);
    check("s6_held", 32'(VALID), 32'h1);
    RST = 1'b1;
    do_slot(1'b1, 1'b0, 1'b0, 1'b0);
    check_all_zero("s6_rst");
    RST = 1'b0;
    for (int i = 0; i < 4; i++) do_slot(1'b1, 1'b0, 1'b0, 1'b1);
    check("s6_hunt_sync", 32'(SYNC_ERR), 32'h0);
    check("s6_hunt_valid", 32'(VALID), 32'h0);
    send_frame(16'h0100, 16'h0100, 1'b1, 1'b1);
    check("s6_mask", 32'(MASK_OUT), 32'h0100);
    check("s6_lock", 32'(LOCKED), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
